// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 16x oversampling with 3-sample majority vote,
// optional parity, 1 or 2 stop bits, and a first-word fall-through receive FIFO.
module uart_rx_cfg #(
   parameter int SYS_CLOCK     = 50000000,
   parameter int UART_BAUDRATE = 115200,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                          i_SysClock,
   input  logic                          i_Reset,
   input  logic                          i_RxSerial,
   output logic [DATA_BITS-1:0]          o_RxData,
   output logic                          o_RxValid,
   input  logic                          i_RxReady,
   output logic                          o_ParityErr,
   output logic                          o_FrameErr,
   output logic                          o_Overrun,
   output logic [$clog2(FIFO_DEPTH):0]   o_Level,
   output logic                          o_Busy
);

   localparam int   OVS_DIV = SYS_CLOCK / (UART_BAUDRATE * 16);
   localparam int   DIV_W   = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
   localparam int   AW      = $clog2(FIFO_DEPTH);
   localparam int   LVL_W   = AW + 1;
   localparam int   WORD_W  = DATA_BITS + 2;
   localparam logic ODD_PAR = (PARITY == 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_e;

   logic                 rx_meta_q, rx_sync_q;
   logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
   logic                 tick;

   state_e               state_q;
   logic [3:0]           tick_cnt_q;
   logic [3:0]           bit_cnt_q;
   logic                 s7_q, s8_q;
   logic                 maj;
   logic [DATA_BITS-1:0] shift_q;
   logic                 perr_q, ferr_q;
   logic                 push_q;
   logic [WORD_W-1:0]    push_word_q;

   logic [WORD_W-1:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]     level_q;
   logic                 overrun_q;
   logic                 empty, full, pop, wr_en;
   logic [WORD_W-1:0]    head;

   // Synchroniser resets to the idle (high) line level so reset never looks like a start bit.
   always_ff @(posedge i_SysClock or posedge i_Reset) begin
      if (i_Reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= i_RxSerial;
         rx_sync_q <= rx_meta_q;
      end
   end

   assign tick = (div_cnt_q == DIV_W'(OVS_DIV - 1));

   // NOTE: combinational blocks assign every output up front so no latch is inferred.
   always_comb begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      if (tick) div_cnt_d = '0;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge i_SysClock or posedge i_Reset) begin
      if (i_Reset) div_cnt_q <= '0;
      else         div_cnt_q <= div_cnt_d;
   end

   assign maj = (s7_q & s8_q) | (s7_q & rx_sync_q) | (s8_q & rx_sync_q);

   always_ff @(posedge i_SysClock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q     <= ST_IDLE;
         tick_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         s7_q        <= 1'b1;
         s8_q        <= 1'b1;
         shift_q     <= '0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         push_q      <= 1'b0;
         push_word_q <= '0;
      end else begin
         push_q <= 1'b0;
         if (state_q == ST_IDLE) begin
            if (!rx_sync_q) begin
               state_q    <= ST_START;
               tick_cnt_q <= '0;
               bit_cnt_q  <= '0;
               perr_q     <= 1'b0;
               ferr_q     <= 1'b0;
            end
         end else if (tick) begin
            tick_cnt_q <= tick_cnt_q + 4'd1;
            if (tick_cnt_q == 4'd7) s7_q <= rx_sync_q;
            if (tick_cnt_q == 4'd8) s8_q <= rx_sync_q;
            // Bit decisions happen at tick 9 (third sample); bit boundaries at tick 15.
            case (state_q)
               ST_START: begin
                  if (tick_cnt_q == 4'd9 && maj) state_q <= ST_IDLE;
                  else if (tick_cnt_q == 4'd15)  state_q <= ST_DATA;
               end
               ST_DATA: begin
                  if (tick_cnt_q == 4'd9) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
                  if (tick_cnt_q == 4'd15) begin
                     if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_q <= '0;
                        state_q   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                     end
                  end
               end
               ST_PARITY: begin
                  if (tick_cnt_q == 4'd9)  perr_q  <= (^shift_q) ^ maj ^ ODD_PAR;
                  if (tick_cnt_q == 4'd15) state_q <= ST_STOP;
               end
               ST_STOP: begin
                  if (tick_cnt_q == 4'd9) begin
                     if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        push_q      <= 1'b1;
                        push_word_q <= {ferr_q | ~maj, perr_q, shift_q};
                        state_q     <= ST_IDLE;
                     end else begin
                        ferr_q <= ferr_q | ~maj;
                     end
                  end
                  if (tick_cnt_q == 4'd15) bit_cnt_q <= bit_cnt_q + 4'd1;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign empty = (level_q == '0);
   assign full  = (level_q == LVL_W'(FIFO_DEPTH));
   assign pop   = !empty && i_RxReady;
   assign wr_en = push_q && (!full || pop);

   // NOTE: storage array carries no reset; validity is tracked by the pointers and level.
   always_ff @(posedge i_SysClock) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_word_q;
   end

   always_ff @(posedge i_SysClock or posedge i_Reset) begin
      if (i_Reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= push_q && full && !pop;
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
         if (wr_en && !pop)      level_q <= level_q + LVL_W'(1);
         else if (pop && !wr_en) level_q <= level_q - LVL_W'(1);
      end
   end

   assign head        = mem_q[rd_ptr_q];
   assign o_RxValid   = !empty;
   assign o_RxData    = empty ? '0 : head[DATA_BITS-1:0];
   assign o_ParityErr = !empty && head[DATA_BITS];
   assign o_FrameErr  = !empty && head[DATA_BITS+1];
   assign o_Overrun   = overrun_q;
   assign o_Level     = level_q;
   assign o_Busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1 instance, even-parity instance, depth-4 FIFO instance.
module tb_uart_rx_cfg;

   localparam int BIT_CYC = 432;

   logic clk = 1'b0;
   logic rst;
   always #10 clk = ~clk;

   logic       line_a, line_b, line_c;
   logic       ready_a, ready_b, ready_c;
   logic [7:0] data_a, data_b, data_c;
   logic       valid_a, valid_b, valid_c;
   logic       perr_a, perr_b, perr_c;
   logic       ferr_a, ferr_b, ferr_c;
   logic       ovr_a, ovr_b, ovr_c;
   logic [3:0] level_a, level_b;
   logic [2:0] level_c;
   logic       busy_a, busy_b, busy_c;

   int checks   = 0;
   int failures = 0;
   int ovr_cnt_a = 0;
   int ovr_cnt_c = 0;

   uart_rx_cfg u_dut_a (
      .i_SysClock(clk), .i_Reset(rst), .i_RxSerial(line_a), .o_RxData(data_a),
      .o_RxValid(valid_a), .i_RxReady(ready_a), .o_ParityErr(perr_a), .o_FrameErr(ferr_a),
      .o_Overrun(ovr_a), .o_Level(level_a), .o_Busy(busy_a)
   );

   uart_rx_cfg #(.PARITY(2)) u_dut_b (
      .i_SysClock(clk), .i_Reset(rst), .i_RxSerial(line_b), .o_RxData(data_b),
      .o_RxValid(valid_b), .i_RxReady(ready_b), .o_ParityErr(perr_b), .o_FrameErr(ferr_b),
      .o_Overrun(ovr_b), .o_Level(level_b), .o_Busy(busy_b)
   );

   uart_rx_cfg #(.FIFO_DEPTH(4)) u_dut_c (
      .i_SysClock(clk), .i_Reset(rst), .i_RxSerial(line_c), .o_RxData(data_c),
      .o_RxValid(valid_c), .i_RxReady(ready_c), .o_ParityErr(perr_c), .o_FrameErr(ferr_c),
      .o_Overrun(ovr_c), .o_Level(level_c), .o_Busy(busy_c)
   );

   always @(posedge clk) begin
      if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
      if (ovr_c) ovr_cnt_c <= ovr_cnt_c + 1;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic drive(input int idx, input logic b);
      case (idx)
         0:       line_a = b;
         1:       line_b = b;
         default: line_c = b;
      endcase
   endtask

   // Sends n bits LSB first; the line is left at the last bit value.
   task automatic send_bits(input int idx, input logic [15:0] bits, input int n);
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         drive(idx, bits[i]);
         repeat (BIT_CYC) @(negedge clk);
      end
   endtask

   task automatic pop(input int idx);
      @(negedge clk);
      case (idx)
         0:       ready_a = 1'b1;
         1:       ready_b = 1'b1;
         default: ready_c = 1'b1;
      endcase
      @(negedge clk);
      ready_a = 1'b0;
      ready_b = 1'b0;
      ready_c = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      line_a = 1'b1; line_b = 1'b1; line_c = 1'b1;
      ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(valid_a), 32'd0);
      check("rst_level", 32'(level_a), 32'd0);
      check("rst_busy",  32'(busy_a),  32'd0);
      check("rst_data",  32'(data_a),  32'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("idle_busy", 32'(busy_a), 32'd0);

      // Depth-4 FIFO: five frames with no consumer
      for (int v = 1; v <= 5; v++) begin
         send_bits(2, 16'({1'b1, 8'(v), 1'b0}), 10);
         repeat (20) @(negedge clk);
         if (v == 4) begin
            check("c_level4", 32'(level_c), 32'd4);
            check("c_no_ovr", 32'(ovr_cnt_c), 32'd0);
         end
      end
      check("c_level_full", 32'(level_c), 32'd4);
      check("c_ovr_once",   32'(ovr_cnt_c), 32'd1);
      for (int v = 1; v <= 4; v++) begin
         check("c_pop_data", 32'(data_c), 32'(v));
         pop(2);
      end
      check("c_level_empty", 32'(level_c), 32'd0);
      check("c_valid_empty", 32'(valid_c), 32'd0);
      check("c_data_empty",  32'(data_c),  32'd0);

      // Even parity: ready while empty, then bad and good parity bits
      pop(1);
      check("b_empty_ready", 32'(level_b), 32'd0);
      send_bits(1, 16'({1'b1, 1'b1, 8'hA5, 1'b0}), 11);
      repeat (20) @(negedge clk);
      check("b_bad_data", 32'(data_b), 32'hA5);
      check("b_bad_perr", 32'(perr_b), 32'd1);
      check("b_bad_ferr", 32'(ferr_b), 32'd0);
      pop(1);
      send_bits(1, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11);
      repeat (20) @(negedge clk);
      check("b_good_data", 32'(data_b), 32'hA5);
      check("b_good_perr", 32'(perr_b), 32'd0);
      pop(1);
      check("b_level", 32'(level_b), 32'd0);

      // 8N1 clean frame
      send_bits(0, 16'({1'b1, 8'h55, 1'b0}), 10);
      repeat (20) @(negedge clk);
      check("a55_valid", 32'(valid_a), 32'd1);
      check("a55_data",  32'(data_a),  32'h55);
      check("a55_perr",  32'(perr_a),  32'd0);
      check("a55_ferr",  32'(ferr_a),  32'd0);
      check("a55_level", 32'(level_a), 32'd1);
      check("a55_busy",  32'(busy_a),  32'd0);
      pop(0);
      check("a55_popped", 32'(level_a), 32'd0);

      // Stop bit held low, then a clean frame
      send_bits(0, 16'({1'b0, 8'h3C, 1'b0}), 10);
      drive(0, 1'b1);
      repeat (1000) @(negedge clk);
      check("a3c_data",  32'(data_a),  32'h3C);
      check("a3c_ferr",  32'(ferr_a),  32'd1);
      check("a3c_perr",  32'(perr_a),  32'd0);
      check("a3c_level", 32'(level_a), 32'd1);
      pop(0);
      send_bits(0, 16'({1'b1, 8'h81, 1'b0}), 10);
      repeat (20) @(negedge clk);
      check("a81_data", 32'(data_a), 32'h81);
      check("a81_ferr", 32'(ferr_a), 32'd0);
      check("a81_perr", 32'(perr_a), 32'd0);

      // 100-cycle glitch: false start, nothing stored (0x81 still held)
      drive(0, 1'b0);
      repeat (60) @(negedge clk);
      check("glitch_busy", 32'(busy_a), 32'd1);
      repeat (40) @(negedge clk);
      drive(0, 1'b1);
      repeat (600) @(negedge clk);
      check("glitch_idle",  32'(busy_a),    32'd0);
      check("glitch_level", 32'(level_a),   32'd1);
      check("glitch_ovr",   32'(ovr_cnt_a), 32'd0);

      // Reset during data bit 3 of 0xF0 (start + bits 0..3 are all low)
      send_bits(0, 16'h0000, 4);
      repeat (200) @(negedge clk);
      check("mid_busy", 32'(busy_a), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy",  32'(busy_a),  32'd0);
      check("mid_rst_level", 32'(level_a), 32'd0);
      check("mid_rst_valid", 32'(valid_a), 32'd0);
      check("mid_rst_data",  32'(data_a),  32'd0);
      check("mid_rst_flags", 32'({ovr_a, perr_a, ferr_a}), 32'd0);
      drive(0, 1'b1);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (500) @(negedge clk);
      check("post_rst_busy",  32'(busy_a),  32'd0);
      check("post_rst_level", 32'(level_a), 32'd0);
      send_bits(0, 16'({1'b1, 8'h5A, 1'b0}), 10);
      repeat (20) @(negedge clk);
      check("a5a_data",  32'(data_a),  32'h5A);
      check("a5a_flags", 32'({perr_a, ferr_a}), 32'd0);
      check("a5a_level", 32'(level_a), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
